// File: rtl/uart_frame_engine_pkg.sv
// uart_frame_engine_pkg: state encodings, data-bit clamp and break-detect rule
package uart_frame_engine_pkg;
  localparam int DBITS_W = 4;
  localparam logic [DBITS_W-1:0] DBITS_MIN = 4'd5;
  typedef enum logic [3:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2, TX_BREAK, TX_MARK
  } tx_state_t;
  typedef enum logic [3:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_MARK
  } rx_state_t;
  function automatic logic [DBITS_W-1:0] clamp_dbits(input logic [DBITS_W-1:0] d,
                                                     input logic [DBITS_W-1:0] dmax);
    return d < DBITS_MIN ? DBITS_MIN : d > dmax ? dmax : d;
  endfunction
  function automatic logic is_break(input logic data_zero, input logic par, input logic stop);
    return data_zero && !par && !stop;
  endfunction
endpackage

// File: rtl/uart_frame_engine_bit_timer.sv
// uart_bit_timer: oversample counter with hold, half-bit preload and terminal tick
module uart_bit_timer #(
  parameter int OVERSAMPLE = 8
) (
  input  logic clk,
  input  logic rst_n_sync,
  input  logic clk_en,
  input  logic clr,
  input  logic load,
  output logic tick
);
  localparam int CW = $clog2(OVERSAMPLE);
  // Preload lands the first zero OVERSAMPLE/2 ticks after the loading tick
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 + 1);
  logic [CW-1:0] ctr;
  always_ff @(posedge clk or negedge rst_n_sync)
    if (!rst_n_sync) ctr <= '0;
    else ctr <= clr ? '0 : load ? HALF : clk_en ? ctr + 1'b1 : ctr;
  always_comb tick = clk_en && ctr == '0;
endmodule

// File: rtl/uart_frame_engine.sv
// uart_frame_engine: UART TX/RX frame engines with parity, 1/2 stop bits and break
module uart_frame_engine
  import uart_frame_engine_pkg::*;
#(
  parameter int W_DATA     = 9,
  parameter int OVERSAMPLE = 8
) (
  input  logic               clk,
  input  logic               rst_n_sync,
  input  logic               en,
  input  logic               clk_en,
  input  logic [DBITS_W-1:0] cfg_dbits,
  input  logic               cfg_parity_en,
  input  logic               cfg_parity_odd,
  input  logic               cfg_stop2,
  input  logic [W_DATA-1:0]  tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic               tx_break,
  output logic               tx_out,
  output logic               tx_busy,
  input  logic               rx_in,
  output logic [W_DATA-1:0]  rx_data,
  output logic               rx_valid,
  output logic               rx_perr,
  output logic               rx_ferr,
  output logic               rx_break
);
  localparam logic [DBITS_W-1:0] DMAX = DBITS_W'(W_DATA);
  logic [DBITS_W-1:0] cfg_nb;
  logic [W_DATA-1:0]  cfg_mask;
  tx_state_t tx_st, tx_st_n;
  logic tx_tick, tx_clr, tx_bound, tx_accept, tx_out_n;
  logic [W_DATA-1:0]  tx_sh;
  logic [DBITS_W-1:0] tx_bcnt, tx_nb;
  logic tx_pen, tx_par, tx_stop2;
  rx_state_t rx_st, rx_st_n;
  logic rx_tick, rx_clr, rx_load, rx_brk;
  logic [W_DATA-1:0]  rx_sh;
  logic [DBITS_W-1:0] rx_bcnt, rx_nb;
  logic rx_pen, rx_odd, rx_par;
  always_comb begin
    cfg_nb = clamp_dbits(cfg_dbits, DMAX);
    cfg_mask = ~({W_DATA{1'b1}} << cfg_nb);
  end
  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_tx_timer (
    .clk(clk), .rst_n_sync(rst_n_sync), .clk_en(clk_en), .clr(tx_clr), .load(1'b0), .tick(tx_tick)
  );
  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_rx_timer (
    .clk(clk), .rst_n_sync(rst_n_sync), .clk_en(clk_en), .clr(rx_clr), .load(rx_load), .tick(rx_tick)
  );
  // Frame boundary: idle, or the last mark period of a frame/break is ending
  always_comb begin
    tx_bound = tx_tick && (tx_st == TX_IDLE || tx_st == TX_STOP2 || tx_st == TX_MARK ||
                           (tx_st == TX_STOP1 && !tx_stop2));
    tx_ready = en && tx_bound && !tx_break;
    tx_accept = tx_ready && tx_valid;
    tx_st_n = tx_st;
    tx_out_n = tx_out;
    if (!en) begin
      tx_st_n = TX_IDLE;
      tx_out_n = 1'b1;
    end else if (tx_bound) begin
      tx_st_n = tx_break ? TX_BREAK : tx_accept ? TX_START : TX_IDLE;
      tx_out_n = !(tx_break || tx_accept);
    end else if (tx_tick)
      case (tx_st)
        TX_START: begin
          tx_st_n = TX_DATA;
          tx_out_n = tx_sh[0];
        end
        TX_DATA: begin
          tx_st_n = tx_bcnt != tx_nb ? TX_DATA : tx_pen ? TX_PARITY : TX_STOP1;
          tx_out_n = tx_bcnt != tx_nb ? tx_sh[0] : tx_pen ? tx_par : 1'b1;
        end
        TX_PARITY: begin
          tx_st_n = TX_STOP1;
          tx_out_n = 1'b1;
        end
        TX_STOP1: tx_st_n = TX_STOP2;
        TX_BREAK: begin
          tx_st_n = tx_break ? TX_BREAK : TX_MARK;
          tx_out_n = !tx_break;
        end
        default: ;
      endcase
    tx_clr = tx_st_n == TX_IDLE || tx_st_n == TX_BREAK;
    tx_busy = tx_st != TX_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n_sync)
    if (!rst_n_sync) begin
      tx_st <= TX_IDLE;
      tx_out <= 1'b1;
    end else begin
      tx_st <= tx_st_n;
      tx_out <= tx_out_n;
    end
  always_ff @(posedge clk or negedge rst_n_sync)
    if (!rst_n_sync) begin
      tx_sh <= '0;
      tx_bcnt <= '0;
      tx_nb <= DBITS_MIN;
      tx_pen <= 1'b0;
      tx_par <= 1'b0;
      tx_stop2 <= 1'b0;
    end else if (!en) tx_bcnt <= '0;
    else if (tx_accept) begin
      tx_sh <= tx_data;
      tx_bcnt <= '0;
      tx_nb <= cfg_nb;
      tx_pen <= cfg_parity_en;
      tx_par <= ^(tx_data & cfg_mask) ^ cfg_parity_odd;
      tx_stop2 <= cfg_stop2;
    end else if (tx_tick && (tx_st == TX_START || (tx_st == TX_DATA && tx_bcnt != tx_nb))) begin
      tx_sh <= tx_sh >> 1;
      tx_bcnt <= tx_bcnt + 1'b1;
    end
  always_comb begin
    rx_brk = is_break(rx_sh == '0, rx_par, rx_in);
    rx_load = 1'b0;
    rx_st_n = rx_st;
    if (!en) rx_st_n = RX_IDLE;
    else if (rx_tick)
      case (rx_st)
        RX_IDLE: begin
          rx_st_n = rx_in ? RX_IDLE : RX_START;
          rx_load = !rx_in;
        end
        RX_START: rx_st_n = rx_in ? RX_IDLE : RX_DATA;
        RX_DATA: rx_st_n = rx_bcnt != rx_nb - 1'b1 ? RX_DATA : rx_pen ? RX_PARITY : RX_STOP;
        RX_PARITY: rx_st_n = RX_STOP;
        RX_STOP: rx_st_n = rx_brk ? RX_WAIT_MARK : RX_IDLE;
        RX_WAIT_MARK: rx_st_n = rx_in ? RX_IDLE : RX_WAIT_MARK;
        default: rx_st_n = RX_IDLE;
      endcase
    rx_clr = rx_st_n == RX_IDLE || rx_st_n == RX_WAIT_MARK;
  end
  always_ff @(posedge clk or negedge rst_n_sync)
    if (!rst_n_sync) rx_st <= RX_IDLE;
    else rx_st <= rx_st_n;
  always_ff @(posedge clk or negedge rst_n_sync)
    if (!rst_n_sync) begin
      rx_sh <= '0;
      rx_bcnt <= '0;
      rx_nb <= DBITS_MIN;
      rx_pen <= 1'b0;
      rx_odd <= 1'b0;
      rx_par <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_perr <= 1'b0;
      rx_ferr <= 1'b0;
      rx_break <= 1'b0;
    end else if (!en) begin
      rx_valid <= 1'b0;
      rx_bcnt <= '0;
    end else begin
      rx_valid <= rx_tick && rx_st == RX_STOP;
      if (rx_tick)
        case (rx_st)
          RX_START:
            if (!rx_in) begin
              rx_sh <= '0;
              rx_bcnt <= '0;
              rx_nb <= cfg_nb;
              rx_pen <= cfg_parity_en;
              rx_odd <= cfg_parity_odd;
              rx_par <= 1'b0;
            end
          RX_DATA: begin
            rx_sh <= rx_sh | (W_DATA'(rx_in) << rx_bcnt);
            rx_bcnt <= rx_bcnt + 1'b1;
          end
          RX_PARITY: rx_par <= rx_in;
          RX_STOP: begin
            rx_data <= rx_sh;
            rx_perr <= rx_pen && (^rx_sh ^ rx_odd ^ rx_par);
            rx_ferr <= !rx_in;
            rx_break <= rx_brk;
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_uart_frame_engine.sv
// tb_uart_frame_engine: directed self-checking bench for uart_frame_engine
module tb_uart_frame_engine;
  logic clk = 1'b0;
  logic rst_n_sync = 1'b0;
  logic en = 1'b0;
  logic clk_en = 1'b1;
  logic [3:0] cfg_dbits = 4'd8;
  logic cfg_parity_en = 1'b0;
  logic cfg_parity_odd = 1'b0;
  logic cfg_stop2 = 1'b0;
  logic [8:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_break = 1'b0;
  logic rx_in = 1'b1;
  logic tx_ready, tx_out, tx_busy, rx_valid, rx_perr, rx_ferr, rx_break;
  logic [8:0] rx_data;
  int vectors = 0;
  int miscompares = 0;
  int npush = 0;
  int p0;
  logic [8:0] cap_data = '0;
  logic cap_perr = 1'b0, cap_ferr = 1'b0, cap_brk = 1'b0;
  uart_frame_engine #(.W_DATA(9), .OVERSAMPLE(8)) dut (
    .clk(clk), .rst_n_sync(rst_n_sync), .en(en), .clk_en(clk_en),
    .cfg_dbits(cfg_dbits), .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
    .cfg_stop2(cfg_stop2), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_break(tx_break), .tx_out(tx_out), .tx_busy(tx_busy), .rx_in(rx_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
    .rx_break(rx_break)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (rx_valid === 1'b1) begin
      npush++;
      cap_data = rx_data;
      cap_perr = rx_perr;
      cap_ferr = rx_ferr;
      cap_brk = rx_break;
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // Caller sits in the accept cycle; samples every cycle of an nbits-long frame
  task automatic run_tx(input string tag, input logic [15:0] bits, input int nbits, input logic keep,
                        input logic [8:0] nxt, input logic mangle, input int rdy_exp);
    int errs = 0;
    int first = -1;
    for (int k = 1; k <= nbits * 8; k++) begin
      step(1);
      if (k == 1) begin
        tx_valid = keep;
        tx_data = nxt;
      end
      if (mangle && k == 20) begin
        cfg_dbits = 4'd8;
        cfg_parity_en = 1'b0;
        cfg_parity_odd = 1'b1;
        cfg_stop2 = 1'b0;
      end
      if (tx_out !== bits[(k-1)/8]) errs++;
      if (tx_ready === 1'b1 && first < 0) first = k;
    end
    chk({tag, "_wave"}, errs, 0);
    chk({tag, "_ready_at"}, first, rdy_exp);
  endtask
  task automatic rx_send(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_in = bits[i];
      step(8);
    end
    rx_in = 1'b1;
    step(8);
  endtask
  initial begin
    step(3);
    chk("rst_tx_out", 32'(tx_out), 1);
    chk("rst_tx_ready", 32'(tx_ready), 0);
    chk("rst_tx_busy", 32'(tx_busy), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_rx_perr", 32'(rx_perr), 0);
    chk("rst_rx_ferr", 32'(rx_ferr), 0);
    chk("rst_rx_break", 32'(rx_break), 0);
    rst_n_sync = 1'b1;
    step(1);
    en = 1'b1;
    step(2);
    tx_data = 9'h0A5;
    tx_valid = 1'b1;
    chk("t1_ready_idle", 32'(tx_ready), 1);
    run_tx("t1", 16'({1'b1, 8'hA5, 1'b0}), 10, 1'b0, 9'h0, 1'b0, 80);
    step(1);
    chk("t1_busy_after", 32'(tx_busy), 0);
    chk("t1_out_after", 32'(tx_out), 1);
    cfg_dbits = 4'd7;
    cfg_parity_en = 1'b1;
    cfg_parity_odd = 1'b0;
    cfg_stop2 = 1'b1;
    tx_data = 9'h0C1;
    tx_valid = 1'b1;
    run_tx("t2", 16'({2'b11, 1'b0, 7'h41, 1'b0}), 11, 1'b0, 9'h0, 1'b1, 88);
    step(1);
    chk("t2_busy_after", 32'(tx_busy), 0);
    cfg_parity_odd = 1'b0;
    cfg_dbits = 4'd15;
    tx_data = 9'h155;
    tx_valid = 1'b1;
    run_tx("clamp_hi", 16'({1'b1, 9'h155, 1'b0}), 11, 1'b0, 9'h0, 1'b0, 88);
    step(1);
    cfg_dbits = 4'd2;
    tx_data = 9'h0F6;
    tx_valid = 1'b1;
    run_tx("clamp_lo", 16'({1'b1, 5'b10110, 1'b0}), 7, 1'b0, 9'h0, 1'b0, 56);
    step(1);
    cfg_dbits = 4'd8;
    tx_break = 1'b1;
    step(1);
    chk("brk_out_low", 32'(tx_out), 0);
    chk("brk_busy", 32'(tx_busy), 1);
    step(19);
    chk("brk_hold_low", 32'(tx_out), 0);
    chk("brk_no_ready", 32'(tx_ready), 0);
    tx_break = 1'b0;
    begin
      int first = -1;
      int out1 = 0;
      for (int k = 1; k <= 8; k++) begin
        step(1);
        if (k == 1) out1 = int'(tx_out);
        if (tx_ready === 1'b1 && first < 0) first = k;
      end
      chk("brk_release_mark", out1, 1);
      chk("brk_mark_ready_at", first, 8);
    end
    step(1);
    chk("brk_idle", 32'(tx_busy), 0);
    tx_data = 9'h011;
    tx_valid = 1'b1;
    run_tx("t6a", 16'({1'b1, 8'h11, 1'b0}), 10, 1'b1, 9'h022, 1'b0, 80);
    run_tx("t6b", 16'({1'b1, 8'h22, 1'b0}), 10, 1'b1, 9'h033, 1'b0, 80);
    run_tx("t6c", 16'({1'b1, 8'h33, 1'b0}), 10, 1'b0, 9'h0, 1'b0, 80);
    step(1);
    chk("t6_busy_after_240", 32'(tx_busy), 0);
    tx_data = 9'h05A;
    tx_valid = 1'b1;
    run_tx("t6d", 16'({1'b1, 8'h5A, 1'b0}), 10, 1'b1, 9'h0C3, 1'b0, 80);
    step(30);
    chk("t6_mid_busy", 32'(tx_busy), 1);
    en = 1'b0;
    step(1);
    chk("en_low_out", 32'(tx_out), 1);
    chk("en_low_busy", 32'(tx_busy), 0);
    chk("en_low_ready", 32'(tx_ready), 0);
    tx_valid = 1'b0;
    en = 1'b1;
    step(2);
    cfg_dbits = 4'd9;
    cfg_parity_en = 1'b1;
    cfg_parity_odd = 1'b1;
    p0 = npush;
    rx_send(16'({1'b1, 1'b0, 9'h1FF, 1'b0}), 12);
    chk("t3a_pushes", npush - p0, 1);
    chk("t3a_data", 32'(cap_data), 32'h1FF);
    chk("t3a_perr", 32'(cap_perr), 0);
    chk("t3a_ferr", 32'(cap_ferr), 0);
    chk("t3a_brk", 32'(cap_brk), 0);
    p0 = npush;
    rx_send(16'({1'b1, 1'b1, 9'h1FF, 1'b0}), 12);
    chk("t3b_pushes", npush - p0, 1);
    chk("t3b_data", 32'(cap_data), 32'h1FF);
    chk("t3b_perr", 32'(cap_perr), 1);
    cfg_dbits = 4'd8;
    cfg_parity_en = 1'b0;
    cfg_parity_odd = 1'b0;
    p0 = npush;
    rx_in = 1'b0;
    step(240);
    rx_in = 1'b1;
    step(16);
    chk("t4_brk_pushes", npush - p0, 1);
    chk("t4_brk_data", 32'(cap_data), 0);
    chk("t4_brk_ferr", 32'(cap_ferr), 1);
    chk("t4_brk_flag", 32'(cap_brk), 1);
    chk("t4_brk_perr", 32'(cap_perr), 0);
    p0 = npush;
    rx_send(16'({1'b1, 8'h3C, 1'b0}), 10);
    chk("t4_next_pushes", npush - p0, 1);
    chk("t4_next_data", 32'(cap_data), 32'h3C);
    chk("t4_next_ferr", 32'(cap_ferr), 0);
    chk("t4_next_brk", 32'(cap_brk), 0);
    p0 = npush;
    rx_send(16'({1'b0, 8'h81, 1'b0}), 10);
    chk("ferr_pushes", npush - p0, 1);
    chk("ferr_data", 32'(cap_data), 32'h81);
    chk("ferr_flag", 32'(cap_ferr), 1);
    chk("ferr_brk", 32'(cap_brk), 0);
    step(8);
    p0 = npush;
    rx_in = 1'b0;
    step(2);
    rx_in = 1'b1;
    step(3);
    chk("t5_glitch_no_push", npush - p0, 0);
    rx_send(16'({1'b1, 8'h96, 1'b0}), 10);
    chk("t5_pushes", npush - p0, 1);
    chk("t5_data", 32'(cap_data), 32'h96);
    chk("t5_ferr", 32'(cap_ferr), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
